mcols: RTL and testbench



---
 rtl/aes_pkg.sv | 42 ++++
 rtl/mcols_if.sv | 27 ++
 rtl/mcols_column.sv | 26 ++
 rtl/mcols.sv | 90 +++++++++
 tb/tb_mcols.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES round-stage types, state address and GF(2^8) helpers.
// Byte k of the 128-bit state sits at [127-8k -: 8]; column c holds bytes 4c..4c+3.
package aes_pkg;

   typedef enum logic [3:0] {
      MC_IDLE,
      MC_SETADDR,
      MC_READ,
      MC_WAIT,
      MC_LOAD,
      MC_MIX,
      MC_WRADDR,
      MC_WRITE,
      MC_FINISH,
      MC_BUFF1,
      MC_BUFF2
   } mcols_state_e;

   localparam logic [15:0] AES_STATE_ADDR = 16'd32;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Row 0 is the most significant byte of a column.
   function automatic logic [7:0] col_byte(input logic [31:0] col, input logic [1:0] r);
      return col[8*(3-int'(r)) +: 8];
   endfunction

   function automatic logic [31:0] get_col(input logic [127:0] st, input logic [1:0] c);
      return st[32*(3-int'(c)) +: 32];
   endfunction

   function automatic logic [127:0] set_col(input logic [127:0] st, input logic [1:0] c,
                                            input logic [31:0] v);
      logic [127:0] r;
      r = st;
      r[32*(3-int'(c)) +: 32] = v;
      return r;
   endfunction

endpackage

// File: rtl/mcols_if.sv
// SRAM-master port set plus the enable/finished handshake shared by the round stages.
// master = the round stage, slave = SRAM/controller side.
interface mcols_if;
   logic [127:0] sramReadValue;
   logic         mcols_enable;
   logic         mcols_finished;
   logic [127:0] sramWriteValue;
   logic         sramRead;
   logic         sramWrite;
   logic         sramDump;
   logic         sramInit;
   logic [15:0]  sramAddr;
   logic [2:0]   sramDumpNum;
   logic [2:0]   sramInitNum;

   modport master (
      input  sramReadValue, mcols_enable,
      output mcols_finished, sramWriteValue, sramRead, sramWrite,
             sramDump, sramInit, sramAddr, sramDumpNum, sramInitNum
   );

   modport slave (
      output sramReadValue, mcols_enable,
      input  mcols_finished, sramWriteValue, sramRead, sramWrite,
             sramDump, sramInit, sramAddr, sramDumpNum, sramInitNum
   );
endinterface

// File: rtl/mcols_column.sv
// One AES MixColumns column: out_r = 2*s_r ^ 3*s_(r+1) ^ s_(r+2) ^ s_(r+3).
// Purely combinational, zero latency.
module mcols_column
   import aes_pkg::*;
(
   input  logic [31:0] col_i,
   output logic [31:0] col_o
);

   logic [7:0] s [4];

   always_comb begin
      for (int r = 0; r < 4; r++) begin
         s[r] = col_byte(col_i, 2'(r));
      end
   end

   always_comb begin
      col_o = '0;
      for (int r = 0; r < 4; r++) begin
         col_o[8*(3-r) +: 8] = xtime(s[r]) ^ xtime(s[(r+1)%4]) ^ s[(r+1)%4]
                               ^ s[(r+2)%4] ^ s[(r+3)%4];
      end
   end

endmodule

// File: rtl/mcols.sv
// MixColumns round stage: SRAM read, one column mixed per cycle, write-back, finished pulse.
// Write at enable+8+READ_WAIT, finished at enable+10+READ_WAIT; enable only sampled in IDLE.
module mcols
   import aes_pkg::*;
#(
   parameter logic [15:0] STATE_ADDR = AES_STATE_ADDR,
   parameter int unsigned READ_WAIT  = 2
) (
   input logic      clk,
   input logic      n_rst,
   mcols_if.master  bus
);

   localparam logic [7:0] WAIT_LAST = 8'(READ_WAIT - 2);

   mcols_state_e state_q;
   logic [127:0] data_q;
   logic [127:0] data_d;
   logic [1:0]   col_q;
   logic [7:0]   wait_q;
   logic         fin_q;
   logic [31:0]  mix_in;
   logic [31:0]  mix_out;

   assign mix_in = get_col(data_q, col_q);

   mcols_column u_col (
      .col_i (mix_in),
      .col_o (mix_out)
   );

   assign data_d = set_col(data_q, col_q, mix_out);

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q <= MC_IDLE;
         data_q  <= '0;
         col_q   <= '0;
         wait_q  <= '0;
         fin_q   <= 1'b0;
      end else begin
         fin_q <= 1'b0;
         case (state_q)
            MC_IDLE:    if (bus.mcols_enable) state_q <= MC_SETADDR;
            MC_SETADDR: state_q <= MC_READ;
            MC_READ: begin
               wait_q  <= '0;
               state_q <= (READ_WAIT > 1) ? MC_WAIT : MC_LOAD;
            end
            MC_WAIT: begin
               wait_q <= wait_q + 8'd1;
               if (wait_q == WAIT_LAST) state_q <= MC_LOAD;
            end
            MC_LOAD: begin
               data_q  <= bus.sramReadValue;
               col_q   <= '0;
               state_q <= MC_MIX;
            end
            MC_MIX: begin
               data_q <= data_d;
               col_q  <= col_q + 2'd1;
               if (col_q == 2'd3) state_q <= MC_WRADDR;
            end
            MC_WRADDR:  state_q <= MC_WRITE;
            MC_WRITE:   state_q <= MC_FINISH;
            MC_FINISH: begin
               fin_q   <= 1'b1;
               data_q  <= '0;
               state_q <= MC_BUFF1;
            end
            MC_BUFF1:   state_q <= MC_BUFF2;
            MC_BUFF2:   state_q <= MC_IDLE;
            default:    state_q <= MC_IDLE;
         endcase
      end
   end

   // Strobes and address decode straight from state so reset forces them low at once.
   assign bus.sramRead       = (state_q == MC_READ);
   assign bus.sramWrite      = (state_q == MC_WRITE);
   assign bus.sramAddr       = (state_q inside {MC_SETADDR, MC_READ, MC_WRADDR, MC_WRITE})
                               ? STATE_ADDR : 16'h0000;
   assign bus.sramWriteValue = data_q;
   assign bus.mcols_finished = fin_q;
   assign bus.sramDump       = 1'b0;
   assign bus.sramInit       = 1'b0;
   assign bus.sramDumpNum    = 3'd0;
   assign bus.sramInitNum    = 3'd0;

endmodule

// File: tb/tb_mcols.sv
// Directed bench for mcols: SRAM model, scoreboard queue of expected write-backs, negedge monitor.
module tb_mcols;

   localparam int RW = 2;

   localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] V2_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
   localparam logic [127:0] V2_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
   localparam logic [127:0] V3_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
   localparam logic [127:0] V3_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

   typedef struct {
      logic [127:0] data;
      int           t0;
   } exp_t;

   logic         clk = 1'b0;
   logic         n_rst;
   int           cyc = 0;
   int           n_cmp = 0;
   int           n_err = 0;
   int           writes = 0;
   bit           quiet = 1'b0;
   bit           prev_fin = 1'b0;
   logic [127:0] mem = '0;
   exp_t         sb[$];

   mcols_if bus();

   mcols #(.STATE_ADDR(16'd32), .READ_WAIT(RW)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name, input string msg);
      n_cmp++;
      n_err++;
      $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_fin();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         seen = bus.mcols_finished;
      end
      if (!seen) fail("finish_timeout", "no finished pulse within 60 cycles");
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [127:0] din, input logic [127:0] dout);
      mem = din;
      bus.mcols_enable = 1'b1;
      sb.push_back('{dout, cyc});
      step(1);
      bus.mcols_enable = 1'b0;
   endtask

   // SRAM read model: data valid only in the cycle RW after the sramRead cycle.
   initial begin
      int age;
      age = -1;
      bus.sramReadValue = '0;
      forever begin
         @(negedge clk);
         if (n_rst === 1'b1 && bus.sramRead === 1'b1) age = 0;
         @(posedge clk);
         #1;
         if (age >= 0) age++;
         bus.sramReadValue = (age == RW) ? mem : '0;
         if (age >= RW) age = -1;
      end
   end

   always @(negedge clk) begin
      if (n_rst === 1'b1) begin
         if (prev_fin) chk("fin_width", 128'(bus.mcols_finished), 128'd0);
         if (bus.sramRead === 1'b1 && !quiet) begin
            if (sb.size() == 0) fail("unexpected_read", "sramRead with nothing pending");
            else chk("read_cycle", 128'(cyc), 128'(sb[0].t0 + 2));
         end
         if (bus.sramWrite === 1'b1) begin
            writes++;
            if (sb.size() == 0) fail("unexpected_write", "sramWrite with nothing pending");
            else begin
               chk("write_data", bus.sramWriteValue, sb[0].data);
               chk("write_cycle", 128'(cyc), 128'(sb[0].t0 + 8 + RW));
               chk("write_addr", 128'(bus.sramAddr), 128'd32);
            end
         end
         if (bus.mcols_finished === 1'b1) begin
            if (sb.size() == 0) fail("unexpected_fin", "finished with nothing pending");
            else begin
               chk("fin_cycle", 128'(cyc), 128'(sb[0].t0 + 10 + RW));
               void'(sb.pop_front());
            end
         end
         prev_fin = (bus.mcols_finished === 1'b1);
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      bit wr_seen;
      n_rst = 1'b0;
      bus.mcols_enable = 1'b1;
      mem = V1_IN;

      // Reset held with enable high
      @(negedge clk);
      chk("rst_read", 128'(bus.sramRead), 128'd0);
      chk("rst_write", 128'(bus.sramWrite), 128'd0);
      chk("rst_addr", 128'(bus.sramAddr), 128'd0);
      chk("rst_wval", bus.sramWriteValue, 128'd0);
      chk("rst_fin", 128'(bus.mcols_finished), 128'd0);
      chk("rst_dump", 128'(bus.sramDump), 128'd0);
      chk("rst_init", 128'(bus.sramInit), 128'd0);
      chk("rst_dumpnum", 128'(bus.sramDumpNum), 128'd0);
      chk("rst_initnum", 128'(bus.sramInitNum), 128'd0);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      sb.push_back('{V1_OUT, cyc});
      @(negedge clk);
      chk("idle_no_read", 128'(bus.sramRead), 128'd0);
      @(posedge clk);
      #1;
      bus.mcols_enable = 1'b0;
      wait_fin();
      step(1);
      chk("wval_idle", bus.sramWriteValue, 128'd0);

      // FIPS-197 round 1 column mix
      start_op(V2_IN, V2_OUT);
      wait_fin();
      step(1);

      // Enable held across completion, then pulses while busy
      mem = V3_IN;
      bus.mcols_enable = 1'b1;
      sb.push_back('{V3_OUT, cyc});
      wait_fin();
      mem = V2_IN;
      sb.push_back('{V2_OUT, cyc + 1});
      step(2);
      bus.mcols_enable = 1'b0;
      step(2);
      bus.mcols_enable = 1'b1;
      chk("busy_dump", 128'(bus.sramDump), 128'd0);
      chk("busy_init", 128'(bus.sramInit), 128'd0);
      chk("busy_nums", 128'({bus.sramDumpNum, bus.sramInitNum}), 128'd0);
      step(1);
      bus.mcols_enable = 1'b0;
      step(3);
      bus.mcols_enable = 1'b1;
      step(1);
      bus.mcols_enable = 1'b0;
      wait_fin();
      step(1);

      // Reset during MIX with column counter at 2
      quiet = 1'b1;
      mem = V1_IN;
      bus.mcols_enable = 1'b1;
      step(1);
      bus.mcols_enable = 1'b0;
      step(6);
      n_rst = 1'b0;
      step(1);
      n_rst = 1'b1;
      @(negedge clk);
      chk("abort_addr", 128'(bus.sramAddr), 128'd0);
      chk("abort_wval", bus.sramWriteValue, 128'd0);
      chk("abort_fin", 128'(bus.mcols_finished), 128'd0);
      wr_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.sramWrite === 1'b1) wr_seen = 1'b1;
         @(negedge clk);
      end
      chk("abort_no_write", 128'(wr_seen), 128'd0);
      quiet = 1'b0;
      step(2);

      chk("sb_drained", 128'(sb.size()), 128'd0);
      chk("write_count", 128'(writes), 128'd4);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
